// File: rtl/psrv32_pkg.sv
// Shared fetch-stage types and constants for the psrv32 core.
package psrv32_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_slot_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(INSTR_BYTES - 1));
  endfunction
endpackage

// File: rtl/pipeline_fetch_perf_cnt.sv
// Fetch-stage performance counters: instructions delivered and stalled-valid cycles.
module pipeline_fetch_perf_cnt
  import psrv32_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_inc_i,
  input  logic            stall_inc_i,
  output logic [XLEN-1:0] fetch_count_o,
  output logic [XLEN-1:0] stall_count_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (fetch_inc_i) fetch_count_o <= fetch_count_o + XLEN'(1);
      if (stall_inc_i) stall_count_o <= stall_count_o + XLEN'(1);
    end
  end
endmodule

// File: rtl/pipeline_fetch.sv
// Single-outstanding instruction fetch stage with hold buffer and branch redirect.
// Optional counters enabled by defining PSRV32_FETCH_PERF_CNT_EN.
module pipeline_fetch
  import psrv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
`ifdef PSRV32_FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count_o,
  output logic [XLEN-1:0] stall_count_o
`endif
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  fetch_slot_t     hold_q, hold_d;
  fetch_slot_t     out_q, out_d;
  logic            valid_q, valid_d;
  logic            out_free;
  fetch_slot_t     resp_slot;

  assign out_free  = !valid_q || !stall_i;
  assign resp_slot = '{instr: imem_rdata_i, pc: req_pc_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      hold_q   <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    hold_d   = hold_q;
    out_d    = out_q;
    valid_d  = valid_q;
    // Decode consumed the current word; it disappears unless replaced below
    if (!stall_i) valid_d = 1'b0;

    unique case (state_q)
      FETCH_REQ: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(INSTR_BYTES);
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = FETCH_REQ;
          drop_d  = 1'b0;
          if (!drop_q) begin
            if (out_free) begin
              out_d   = resp_slot;
              valid_d = 1'b1;
            end else begin
              hold_d  = resp_slot;
              state_d = FETCH_HOLD;
            end
          end
        end
      end
      FETCH_HOLD: begin
        if (!stall_i) begin
          out_d   = hold_q;
          valid_d = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase

    // Redirect beats stall; a response still in flight must be swallowed first
    if (branch_taken_i) begin
      out_d   = out_q;
      hold_d  = hold_q;
      valid_d = 1'b0;
      pc_d    = word_align(branch_target_i);
      if ((state_q == FETCH_REQ && imem_gnt_i) ||
          (state_q == FETCH_WAIT && !imem_rvalid_i)) begin
        state_d = FETCH_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = FETCH_REQ;
        drop_d  = 1'b0;
      end
    end
  end

  assign imem_req_o    = rst_ni && (state_q == FETCH_REQ);
  assign imem_addr_o   = pc_q;
  assign instruction_o = out_q.instr;
  assign pc_o          = out_q.pc;
  assign valid_o       = valid_q;

`ifdef PSRV32_FETCH_PERF_CNT_EN
  // A new word lands in the output exactly when valid is set while the slot is free
  logic fetch_inc;
  assign fetch_inc = valid_d && out_free;

  pipeline_fetch_perf_cnt u_perf_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_inc_i   (fetch_inc),
    .stall_inc_i   (stall_i && valid_q),
    .fetch_count_o (fetch_count_o),
    .stall_count_o (stall_count_o)
  );
`endif
endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: transaction-level model plus literal checks.
`timescale 1ns/1ps
module tb_pipeline_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] tgt = '0, rdata = '0;
  logic        req, vld, req2, vld2;
  logic [31:0] addr, instr, pco, addr2, instr2, pco2;
`ifdef PSRV32_FETCH_PERF_CNT_EN
  logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pipeline_fetch dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instruction_o(instr), .pc_o(pco), .valid_o(vld)
`ifdef PSRV32_FETCH_PERF_CNT_EN
    , .fetch_count_o(fcnt), .stall_count_o(scnt)
`endif
  );

  // Free-running instance checking the top-of-address-space wrap
  pipeline_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0), .branch_taken_i(1'b0),
    .branch_target_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(1'b1), .imem_rvalid_i(1'b1), .imem_rdata_i(32'h0000_0013),
    .instruction_o(instr2), .pc_o(pco2), .valid_o(vld2)
`ifdef PSRV32_FETCH_PERF_CNT_EN
    , .fetch_count_o(fcnt2), .stall_count_o(scnt2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-flight request slot, a parked-word buffer and the output slot
  logic [31:0] m_pc, m_infl_pc, m_buf_i, m_buf_p, m_out_i, m_out_p, m_fcnt, m_scnt;
  logic        m_busy, m_discard, m_buf_v, m_out_v, exp_req;
  assign exp_req = rst_n && !m_busy && !m_buf_v;

  always @(posedge clk or negedge rst_n) begin : model
    logic fire, resp, free;
    if (!rst_n) begin
      m_pc <= 32'h0; m_infl_pc <= '0; m_buf_i <= '0; m_buf_p <= '0;
      m_out_i <= '0; m_out_p <= '0; m_fcnt <= '0; m_scnt <= '0;
      m_busy <= 1'b0; m_discard <= 1'b0; m_buf_v <= 1'b0; m_out_v <= 1'b0;
    end else begin
      fire = exp_req && gnt;
      resp = m_busy && rvalid;
      free = !m_out_v || !stall;
      if (stall && m_out_v) m_scnt <= m_scnt + 1;
      if (br) begin
        m_out_v <= 1'b0;
        m_buf_v <= 1'b0;
        m_pc    <= tgt & 32'hFFFF_FFFC;
        if (fire) begin m_busy <= 1'b1; m_discard <= 1'b1; end
        else if (resp) begin m_busy <= 1'b0; m_discard <= 1'b0; end
        else if (m_busy) m_discard <= 1'b1;
      end else begin
        if (resp && !m_discard && free) begin
          m_out_v <= 1'b1; m_out_i <= rdata; m_out_p <= m_infl_pc; m_fcnt <= m_fcnt + 1;
        end else if (resp && !m_discard) begin
          m_buf_v <= 1'b1; m_buf_i <= rdata; m_buf_p <= m_infl_pc;
        end else if (m_buf_v && !stall) begin
          m_out_v <= 1'b1; m_out_i <= m_buf_i; m_out_p <= m_buf_p; m_buf_v <= 1'b0;
          m_fcnt <= m_fcnt + 1;
        end else if (!stall) m_out_v <= 1'b0;
        if (resp) begin m_busy <= 1'b0; m_discard <= 1'b0; end
        if (fire) begin m_busy <= 1'b1; m_infl_pc <= m_pc; m_pc <= m_pc + 4; end
      end
    end
  end

  always @(negedge clk) begin
    check("req", {31'b0, req}, {31'b0, exp_req});
    if (exp_req) check("addr", addr, m_pc);
    check("valid", {31'b0, vld}, {31'b0, m_out_v});
    if (m_out_v || !rst_n) begin
      check("instr", instr, m_out_i);
      check("pc_o", pco, m_out_p);
    end
`ifdef PSRV32_FETCH_PERF_CNT_EN
    check("fetch_cnt", fcnt, m_fcnt);
    check("stall_cnt", scnt, m_scnt);
`endif
  end

  task automatic cyc(input logic s, input logic b, input logic [31:0] t,
                     input logic g, input logic v, input logic [31:0] d);
    stall = s; br = b; tgt = t; gnt = g; rvalid = v; rdata = d;
    @(posedge clk); #1;
    stall = 1'b0; br = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, vld}, 32'd0);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_o", pco, 32'h0);
    rst_n = 1'b1;
    #1;
    check("first_req", {31'b0, req}, 32'd1);
    check("first_addr", addr, 32'h0);
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 0, 0);
    check("wait_noreq", {31'b0, req}, 32'd0);
    check("wrap_wait", {31'b0, req2}, 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h0050_0093);
    check("lat_valid", {31'b0, vld}, 32'd1);
    check("lat_pc", pco, 32'h0);
    check("lat_instr", instr, 32'h0050_0093);
    check("next_addr", addr, 32'h4);
    check("wrap_addr1", addr2, 32'h0);
    check("wrap_pc_o", pco2, 32'hFFFF_FFFC);

    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0010_0013);
    check("pc4", pco, 32'h4);

    // Response arrives while decode is stalled on a valid word
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h00A0_0113);
    check("hold_pc", pco, 32'h4);
    check("hold_instr", instr, 32'h0010_0013);
    check("hold_noreq", {31'b0, req}, 32'd0);
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0, 0);
    check("unhold_pc", pco, 32'h8);
    check("unhold_instr", instr, 32'h00A0_0113);

    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0000_0103, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("br_wait_valid", {31'b0, vld}, 32'd0);
    check("br_wait_addr", addr, 32'h0000_0100);

    cyc(0, 1, 32'h0000_0200, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hBAAD_F00D);
    check("br_gnt_addr", addr, 32'h0000_0200);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0000_0302, 0, 1, 32'hCAFE_F00D);
    check("br_rv_valid", {31'b0, vld}, 32'd0);
    check("br_rv_addr", addr, 32'h0000_0300);

    // Branch while a word is parked and decode is stalled
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1111_1111);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h2222_2222);
    cyc(1, 1, 32'h0000_0400, 0, 0, 0);
    check("br_hold_valid", {31'b0, vld}, 32'd0);
    check("br_hold_addr", addr, 32'h0000_0400);
    cyc(0, 0, 0, 0, 1, 32'h3333_3333);
    check("stray_rv", {31'b0, vld}, 32'd0);

    // Reset with a request outstanding; the late response must be ignored
    cyc(0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 1, 32'h4444_4444);
    check("rst_mid_valid", {31'b0, vld}, 32'd0);
    check("rst_mid_addr", addr, 32'h0);

    // Three fetches with two stalled-valid cycles
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0001);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0002);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0003);
    check("cnt_pc", pco, 32'h8);
`ifdef PSRV32_FETCH_PERF_CNT_EN
    check("fetch_cnt3", fcnt, 32'd3);
    check("stall_cnt2", scnt, 32'd2);
`endif
    rst_n = 1'b0;
    #1;
`ifdef PSRV32_FETCH_PERF_CNT_EN
    check("fetch_cnt_rst", fcnt, 32'd0);
    check("stall_cnt_rst", scnt, 32'd0);
`endif
    check("final_valid", {31'b0, vld}, 32'd0);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
